// File: rtl/systolic_act_feeder_if.sv
// Input vector stream handshake into systolic_act_feeder.
interface systolic_act_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 32
);
  logic                             in_valid;
  logic                             in_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data;
  logic                             in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/systolic_act_feeder.sv
// Activation feeder for systolic_array: input FIFO, diagonal skew, zero-flush drain.
// Optional stall_cycles counter enabled by defining FEEDER_STALL_CNT_EN.
module systolic_act_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  systolic_act_feeder_if.slave             in_if,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_out,
  output logic                             array_enable,
  output logic                             busy,
  output logic                             done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                      stall_cycles
`endif
);

  localparam int VEC_W      = ARRAY_SIZE * DATA_WIDTH;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = PTR_W + 1;
  localparam int DRAIN_INIT = 2 * ARRAY_SIZE - 1;
  localparam int DRAIN_W    = (ARRAY_SIZE > 1) ? $clog2(2 * ARRAY_SIZE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_r;
  logic [DRAIN_W-1:0]   drain_cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 enable_r;
  logic                 in_ready_r;

  logic [VEC_W:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_nxt_s;

  logic                 push_s;
  logic                 pop_s;
  logic                 empty_s;
  logic                 advance_s;
  logic                 head_last_s;
  logic [VEC_W-1:0]     skew_in_s;

  assign push_s    = in_if.in_valid && in_ready_r;
  assign empty_s   = (count_r == '0);
  assign pop_s     = (state_r == ST_STREAM) && !empty_s;
  assign advance_s = pop_s || (state_r == ST_DRAIN);

  // Next FIFO occupancy from the push/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_if.in_last, in_if.in_data};
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r    <= count_nxt_s;
      in_ready_r <= (count_nxt_s != CNT_W'(FIFO_DEPTH));
    end
  end

  assign in_if.in_ready = in_ready_r;

  // Skew input: FIFO head while streaming, zero fill otherwise
  always_comb begin
    head_last_s = mem_r[rd_ptr_r][VEC_W];
    if (state_r == ST_STREAM) begin
      skew_in_s = mem_r[rd_ptr_r][VEC_W-1:0];
    end else begin
      skew_in_s = '0;
    end
  end

  // Row i: i delay stages then an output register, all gated by advance
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
    logic [DATA_WIDTH-1:0] row_in_s;
    logic [DATA_WIDTH-1:0] row_out_r;
    assign row_in_s = skew_in_s[i*DATA_WIDTH +: DATA_WIDTH];

    if (i == 0) begin : g_direct
      // Row 0 output register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          row_out_r <= '0;
        end else if (advance_s) begin
          row_out_r <= row_in_s;
        end
      end
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] dly_r [i];
      // Delay chain plus output register for this row
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < i; k++) dly_r[k] <= '0;
          row_out_r <= '0;
        end else if (advance_s) begin
          dly_r[0] <= row_in_s;
          for (int k = 1; k < i; k++) dly_r[k] <= dly_r[k-1];
          row_out_r <= dly_r[i-1];
        end
      end
    end

    assign act_out[i*DATA_WIDTH +: DATA_WIDTH] = row_out_r;
  end

  // Tile sequencing FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      enable_r    <= 1'b0;
    end else begin
      enable_r <= advance_s;
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_STREAM;
            busy_r  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (pop_s && head_last_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= DRAIN_W'(DRAIN_INIT);
          end
        end
        ST_DRAIN: begin
          drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
          if (drain_cnt_r == DRAIN_W'(1)) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign array_enable = enable_r;
  assign busy         = busy_r;
  assign done         = done_r;

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of starved STREAM cycles, cleared at tile start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == ST_STREAM) && empty_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule
